// File: rtl/nexys_board_io.sv
// Board I/O conditioning: synchronised, debounced buttons/switches with edge pulses, and LED drive.
// Define BOARD_IO_LED_PWM_EN to add glitch-free PWM dimming of the LEDs; otherwise LEDs pass through registered.
module nexys_board_io #(
  parameter int unsigned NUM_BTN         = 5,
  parameter int unsigned NUM_SW          = 2,
  parameter int unsigned NUM_LED         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned PWM_BITS        = 8
) (
  input  logic                ref_clk,
  input  logic                ref_rst,
  input  logic [NUM_BTN-1:0]  btn_pad_i,
  input  logic [NUM_SW-1:0]   sw_pad_i,
  output logic [NUM_BTN-1:0]  btn_o,
  output logic [NUM_BTN-1:0]  btn_rise_o,
  output logic [NUM_BTN-1:0]  btn_fall_o,
  output logic [NUM_SW-1:0]   sw_o,
  input  logic [NUM_LED-1:0]  led_i,
  input  logic [PWM_BITS-1:0] brightness_i,
  output logic [NUM_LED-1:0]  led_pad_o
);

  localparam int unsigned NUM_CH  = NUM_BTN + NUM_SW;
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] pad;
  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [NUM_CH-1:0] stable;

  // Buttons occupy the low channels, switches the high ones.
  assign pad = {sw_pad_i, btn_pad_i};

  always_ff @(posedge ref_clk) begin
    if (ref_rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             stable_q;
    logic             accept;

    // A new level is accepted once it has differed from stable for DEBOUNCE_CYCLES samples.
    assign accept = (sync2[i] != stable_q) && (cnt == CNT_MAX);

    always_ff @(posedge ref_clk) begin
      if (ref_rst) begin
        cnt      <= '0;
        stable_q <= 1'b0;
      end else if (sync2[i] == stable_q) begin
        cnt <= '0;
      end else if (accept) begin
        cnt      <= '0;
        stable_q <= sync2[i];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign stable[i] = stable_q;

    if (i < NUM_BTN) begin : g_edge
      logic rise_q;
      logic fall_q;

      always_ff @(posedge ref_clk) begin
        if (ref_rst) begin
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          rise_q <= accept & sync2[i];
          fall_q <= accept & ~sync2[i];
        end
      end

      assign btn_rise_o[i] = rise_q;
      assign btn_fall_o[i] = fall_q;
    end
  end

  assign btn_o = stable[NUM_BTN-1:0];
  assign sw_o  = stable[NUM_CH-1:NUM_BTN];

`ifdef BOARD_IO_LED_PWM_EN
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;

  // Duty only reloads on the last count so every period uses a single duty value.
  always_ff @(posedge ref_clk) begin
    if (ref_rst) begin
      pwm_cnt   <= '0;
      duty      <= '0;
      led_pad_o <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (pwm_cnt == PWM_MAX) begin
        duty <= brightness_i;
      end
      led_pad_o <= led_i & {NUM_LED{pwm_cnt < duty}};
    end
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness_i;

  always_ff @(posedge ref_clk) begin
    if (ref_rst) begin
      led_pad_o <= '0;
    end else begin
      led_pad_o <= led_i;
    end
  end
`endif

endmodule

// File: tb/tb_nexys_board_io.sv
// Directed bench for nexys_board_io (DEBOUNCE_CYCLES=8, PWM_BITS=4); PWM checks apply when BOARD_IO_LED_PWM_EN is defined.
`timescale 1ns/1ps
module tb_nexys_board_io;

  localparam int unsigned NB = 5;
  localparam int unsigned NS = 2;
  localparam int unsigned NL = 4;
  localparam int unsigned DB = 8;
  localparam int unsigned PB = 4;

  logic          ref_clk = 1'b0;
  logic          ref_rst;
  logic [NB-1:0] btn_pad_i;
  logic [NS-1:0] sw_pad_i;
  logic [NB-1:0] btn_o;
  logic [NB-1:0] btn_rise_o;
  logic [NB-1:0] btn_fall_o;
  logic [NS-1:0] sw_o;
  logic [NL-1:0] led_i;
  logic [PB-1:0] brightness_i;
  logic [NL-1:0] led_pad_o;

  int n_assert = 0;
  int n_fail   = 0;

  nexys_board_io #(
    .NUM_BTN(NB), .NUM_SW(NS), .NUM_LED(NL), .DEBOUNCE_CYCLES(DB), .PWM_BITS(PB)
  ) dut (
    .ref_clk(ref_clk), .ref_rst(ref_rst),
    .btn_pad_i(btn_pad_i), .sw_pad_i(sw_pad_i),
    .btn_o(btn_o), .btn_rise_o(btn_rise_o), .btn_fall_o(btn_fall_o),
    .sw_o(sw_o), .led_i(led_i), .brightness_i(brightness_i), .led_pad_o(led_pad_o)
  );

  always #5 ref_clk = ~ref_clk;

`ifdef BOARD_IO_LED_PWM_EN
  // Phase reference: value the PWM counter holds after each edge.
  logic [PB-1:0] ph;
  always @(posedge ref_clk) begin
    if (ref_rst) ph <= '0;
    else         ph <= ph + 4'd1;
  end
`endif

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge ref_clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    ref_rst      = 1'b1;
    btn_pad_i    = '0;
    sw_pad_i     = '0;
    led_i        = '0;
    brightness_i = '0;
    tick(3);
    check("rst_btn",  16'(btn_o), 16'h0);
    check("rst_rise", 16'(btn_rise_o), 16'h0);
    check("rst_fall", 16'(btn_fall_o), 16'h0);
    check("rst_sw",   16'(sw_o), 16'h0);
    check("rst_led",  16'(led_pad_o), 16'h0);
    ref_rst = 1'b0;
    tick(2);

    // Clean press and release on button 0
    btn_pad_i[0] = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check("press_wait",   16'(btn_o), 16'h0);
      check("press_norise", 16'(btn_rise_o), 16'h0);
    end
    tick();
    check("press_level", 16'(btn_o), 16'h1);
    check("press_rise",  16'(btn_rise_o), 16'h1);
    tick();
    check("press_rise_once", 16'(btn_rise_o), 16'h0);
    check("press_hold",      16'(btn_o), 16'h1);
    tick(9);
    btn_pad_i[0] = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check("rel_wait",   16'(btn_o), 16'h1);
      check("rel_nofall", 16'(btn_fall_o), 16'h0);
    end
    tick();
    check("rel_level", 16'(btn_o), 16'h0);
    check("rel_fall",  16'(btn_fall_o), 16'h1);
    tick();
    check("rel_fall_once", 16'(btn_fall_o), 16'h0);

    // Bouncing button 2: 1,0,1,0 for 3 cycles each, then held high
    for (int k = 0; k < 4; k++) begin
      btn_pad_i[2] = (k % 2 == 0);
      for (int c = 0; c < 3; c++) begin
        tick();
        check("bounce_level", 16'(btn_o), 16'h0);
        check("bounce_pulse", 16'(btn_rise_o | btn_fall_o), 16'h0);
      end
    end
    btn_pad_i[2] = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check("bounce_wait", 16'(btn_o | btn_rise_o | btn_fall_o), 16'h0);
    end
    tick();
    check("bounce_level_hi", 16'(btn_o), 16'h4);
    check("bounce_rise",     16'(btn_rise_o), 16'h4);
    check("bounce_nofall",   16'(btn_fall_o), 16'h0);
    for (int e = 0; e < 4; e++) begin
      tick();
      check("bounce_after", 16'(btn_rise_o | btn_fall_o), 16'h0);
      check("bounce_keep",  16'(btn_o), 16'h4);
    end

    // Button 3: 7-cycle glitch is rejected
    btn_pad_i[3] = 1'b1;
    tick(7);
    btn_pad_i[3] = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      check("glitch7_level", 16'(btn_o), 16'h4);
      check("glitch7_pulse", 16'(btn_rise_o | btn_fall_o), 16'h0);
    end

    // Button 3: 8-cycle pulse is accepted, released 8 edges later
    btn_pad_i[3] = 1'b1;
    tick(8);
    btn_pad_i[3] = 1'b0;
    tick();
    check("pulse8_wait", 16'(btn_o), 16'h4);
    tick();
    check("pulse8_level", 16'(btn_o), 16'hC);
    check("pulse8_rise",  16'(btn_rise_o), 16'h8);
    for (int e = 11; e <= 17; e++) begin
      tick();
      check("pulse8_hold", 16'(btn_o), 16'hC);
      check("pulse8_quiet", 16'(btn_rise_o | btn_fall_o), 16'h0);
    end
    tick();
    check("pulse8_fall_level", 16'(btn_o), 16'h4);
    check("pulse8_fall",       16'(btn_fall_o), 16'h8);
    tick(3);

    // Several channels changing together
    btn_pad_i = 5'b10110;
    sw_pad_i  = 2'b01;
    tick(9);
    check("multi_wait_btn", 16'(btn_o), 16'h04);
    check("multi_wait_sw",  16'(sw_o), 16'h0);
    tick();
    check("multi_btn",  16'(btn_o), 16'h16);
    check("multi_rise", 16'(btn_rise_o), 16'h12);
    check("multi_sw",   16'(sw_o), 16'h1);
    tick(2);

    // Reset in the middle of switch 1 debounce
    sw_pad_i[1] = 1'b1;
    tick(5);
    check("midrst_pre", 16'(sw_o), 16'h1);
    ref_rst = 1'b1;
    tick(3);
    check("midrst_sw",   16'(sw_o), 16'h0);
    check("midrst_btn",  16'(btn_o), 16'h0);
    check("midrst_rise", 16'(btn_rise_o), 16'h0);
    ref_rst = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check("postrst_sw",  16'(sw_o), 16'h0);
      check("postrst_btn", 16'(btn_o), 16'h0);
    end
    tick();
    check("postrst_sw_hi",  16'(sw_o), 16'h3);
    check("postrst_btn_hi", 16'(btn_o), 16'h16);
    check("postrst_rise",   16'(btn_rise_o), 16'h16);
    tick();

`ifdef BOARD_IO_LED_PWM_EN
    // Duty 5: each period starts with 5 high samples
    led_i        = 4'hF;
    brightness_i = 4'd5;
    tick(20);
    while (ph != 4'd1) tick();
    for (int p = 0; p < 2; p++) begin
      int hi = 0;
      for (int s = 0; s < 16; s++) begin
        check("pwm5_sample", 16'(led_pad_o), (s < 5) ? 16'hF : 16'h0);
        if (led_pad_o == 4'hF) hi++;
        tick();
      end
      check("pwm5_count", 16'(hi), 16'd5);
    end

    // Duty 0: always off
    brightness_i = 4'd0;
    tick(20);
    for (int s = 0; s < 16; s++) begin
      check("pwm0_sample", 16'(led_pad_o), 16'h0);
      tick();
    end

    // 12 -> 3 changed mid-period takes effect only at the next period
    brightness_i = 4'd12;
    tick(20);
    while (ph != 4'd1) tick();
    for (int p = 0; p < 2; p++) begin
      int hi = 0;
      for (int s = 0; s < 16; s++) begin
        check("pwmupd_sample", 16'(led_pad_o), (s < ((p == 0) ? 12 : 3)) ? 16'hF : 16'h0);
        if (led_pad_o == 4'hF) hi++;
        if (p == 0 && s == 5) brightness_i = 4'd3;
        tick();
      end
      check("pwmupd_count", 16'(hi), (p == 0) ? 16'd12 : 16'd3);
    end
`else
    // Pass-through LEDs with one-cycle latency, brightness ignored
    brightness_i = 4'd0;
    led_i        = 4'b1000;
    #1;
    check("led_not_yet", 16'(led_pad_o), 16'h0);
    tick();
    check("led3_on", 16'(led_pad_o), 16'h8);
    for (int e = 0; e < 5; e++) begin
      brightness_i = 4'(e * 3);
      tick();
      check("led3_hold", 16'(led_pad_o), 16'h8);
    end
    led_i        = 4'b0101;
    brightness_i = 4'hF;
    tick();
    check("led_0101", 16'(led_pad_o), 16'h5);
    led_i = 4'b0000;
    tick();
    check("led_off", 16'(led_pad_o), 16'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/nexys_board_io.md
# nexys_board_io

Board-level I/O conditioning block for the Nexys FPGA target, placed between the raw board pins (push-buttons, slide switches, LEDs) and the SoC pad signals in the FPGA top level. It replaces direct pin-to-pad wiring with parametrised channel counts and adds three functions:
- per-channel synchronisation and debouncing of buttons and switches, with one-cycle edge pulses;
- PWM brightness control of the LEDs;
- glitch-free brightness updates.

## Interface
Parameters:
- NUM_BTN, 5, number of push-button channels (1..16)
- NUM_SW, 2, number of slide-switch channels (1..16)
- NUM_LED, 4, number of LED channels (1..16)
- DEBOUNCE_CYCLES, 100000, stable-sample count required to accept a new input level (>= 2)
- PWM_BITS, 8, width of PWM counter and brightness value (2..16)

Ports:
- ref_clk  in  1  board reference clock; all logic on its rising edge
- ref_rst  in  1  reset: synchronous, active-high
- btn_pad_i  in  NUM_BTN  raw button pins, asynchronous
- sw_pad_i  in  NUM_SW  raw switch pins, asynchronous
- btn_o  out  NUM_BTN  debounced button level
- btn_rise_o  out  NUM_BTN  one-cycle pulse on accepted 0->1 of btn_o
- btn_fall_o  out  NUM_BTN  one-cycle pulse on accepted 1->0 of btn_o
- sw_o  out  NUM_SW  debounced switch level
- led_i  in  NUM_LED  LED on/off request from the SoC
- brightness_i  in  PWM_BITS  global LED duty value
- led_pad_o  out  NUM_LED  LED pin drive

## Operation
- Input channels: buttons and switches share one channel structure, instantiated NUM_BTN + NUM_SW times.
  - Synchroniser: two flops, sync1 then sync2.
  - Debounce state per channel: stable bit and counter, width clog2(DEBOUNCE_CYCLES).
- Debounce rule, per rising edge:
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0.
  - Any bounce back to the stable level before the count completes clears the counter, so no output change occurs.
- Edge pulses:
  - btn_rise_o[i] is asserted for exactly the one cycle in which stable[i] changes 0->1; btn_fall_o[i] likewise for 1->0.
  - Switches have no edge outputs.
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter that wraps from 2^PWM_BITS-1 to 0.
  - duty is latched from brightness_i only in the cycle where pwm_cnt == 2^PWM_BITS-1, so a period never uses a mixed duty.
  - led_pad_o[i] <= led_i[i] & (pwm_cnt < duty), registered.
  - duty 0 gives always off. Duty D gives D high cycles per 2^PWM_BITS-cycle period; the maximum value gives 2^PWM_BITS-1 high cycles.
- Reset values: sync flops, stable, counters, btn_o, sw_o, btn_rise_o, btn_fall_o, pwm_cnt, duty and led_pad_o are all 0.
- Reset mid-debounce: the pending change is discarded. After reset release, a pin held high needs the full latency below again.
- Multiple channels may change in the same cycle; they are fully independent.

## Timing
- Pin change, then held steady: stable/btn_o/sw_o changes on rising edge DEBOUNCE_CYCLES+2 after the first edge that samples the new level. The rise/fall pulse appears in that same cycle.
- A glitch of at most DEBOUNCE_CYCLES-1 cycles, as seen at sync2, produces no output change.
- led_i change: led_pad_o follows on the next edge, gated by the current PWM phase.
- brightness_i change: effective from the first period that starts after the next wrap. Worst case is 2^PWM_BITS+1 cycles.
- The PWM period is exactly 2^PWM_BITS cycles.

## Configuration
- BOARD_IO_LED_PWM_EN defined: the PWM counter, duty latch and gating are present as described.
- BOARD_IO_LED_PWM_EN undefined:
  - pwm_cnt and duty are not built, and brightness_i is ignored.
  - led_pad_o <= led_i, registered, so LEDs are fully on when requested, with 1-cycle latency.
  - Debounce behaviour is unchanged.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8 and PWM_BITS=4.
- Clean press: btn_pad_i[0] 0->1 held 20 cycles -> btn_o[0]=1 on edge 10 after the first sampling edge, btn_rise_o[0] high for exactly that one cycle. Release gives btn_fall_o[0] one pulse 10 edges later.
- Bounce: btn_pad_i[2] toggles 1,0,1,0 at 3-cycle intervals, then holds 1 -> exactly one btn_rise_o[2] pulse, 10 edges after the final transition; no fall pulse.
- Reset mid-debounce: sw_pad_i[1]=1, ref_rst pulsed 5 cycles after the change -> sw_o[1] stays 0 through reset. It goes to 1 on edge 10 after release.
- PWM duty: led_i=4'b1111, brightness_i=5 -> after the first wrap, each 16-cycle period has led_pad_o high for exactly 5 cycles. brightness_i=0 gives constant 0.
- Glitch-free update: brightness_i changed from 12 to 3 at pwm_cnt=6 -> the current period still completes with 12 high cycles; the next period has 3.
- Macro off: BOARD_IO_LED_PWM_EN undefined, led_i[3] 0->1 -> led_pad_o[3]=1 one edge later and stays high, regardless of brightness_i.
